cmem_arbiter: RTL and testbench
===============================

# cmem_arbiter

Two-requester arbiter and sequencer for the shared layer-memory port (csel/cwr/crd/caddr/cdata bus) of the image-convolution design. Requester 0 is the convolution engine writing layer-0 results; requester 1 is the max-pool engine reading 2x2 windows and writing layer-1 results. The block grants the port one beat at a time with round-robin fairness, supports locked bursts bounded by a hold limit, registers every memory command and returns read data with fixed latency.

## Interface
- AW, 12, memory address width
- DW, 20, memory data width
- MAX_HOLD, 8, max consecutive accepted beats under lock while the other requester waits
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- rN_req  in  1  requester N (N=0,1) has a valid command
- rN_lock  in  1  requester N wants to keep ownership after this beat
- rN_we  in  1  1 = write, 0 = read
- rN_sel  in  3  target memory bank (driven to csel)
- rN_addr  in  AW  beat address
- rN_wdata  in  DW  write data
- rN_gnt  out  1  requester N owns the port; beat accepted when rN_req & rN_gnt
- rN_rvalid  out  1  one-cycle pulse, read data for requester N on rdata
- rdata  out  DW  registered read data
- cwr  out  1  memory write strobe
- crd  out  1  memory read strobe
- csel  out  3  memory bank select
- caddr_wr  out  AW  write address
- caddr_rd  out  AW  read address
- cdata_wr  out  DW  write data
- cdata_rd  in  DW  memory read data, valid the cycle after crd=1

## Operation
- States: IDLE, OWN0, OWN1. rN_gnt = (state == OWNN), decoded from the state register.
- IDLE: one requester asserting req → its OWN state. Both asserting → requester not served last (last_owner register; reset value 1, so R0 wins first).
- OWNN, accepted beat, rN_lock=0: other req=1 → OWN of other; else own req stays → OWNN; else IDLE.
- OWNN, accepted beat, rN_lock=1: stay OWNN unless other req=1 and hold_cnt = MAX_HOLD-1, then forced switch.
- OWNN, rN_req=0: other req → other OWN, else IDLE (no command issued).
- Switch between owners takes one edge, no IDLE bubble; last_owner updates on every switch away.
- hold_cnt: clears on ownership change or when owner drops lock; increments per accepted beat; saturates at MAX_HOLD-1.
- Accepted write: next edge cwr=1, caddr_wr=addr, cdata_wr=wdata, csel=sel, crd=0.
- Accepted read: next edge crd=1, caddr_rd=addr, csel=sel, cwr=0.
- Read return: edge after crd=1 registers rdata=cdata_rd and pulses rN_rvalid for the issuing requester (tag register of 1 bit).
- No accepted beat: cwr=0, crd=0; csel, caddr_wr, caddr_rd, cdata_wr hold last values.

## Timing
- Reset (asynchronous, reset=0): state=IDLE, last_owner=1, hold_cnt=0, all outputs 0 (gnt, rvalid, cwr, crd, csel, addresses, data).
- req to first gnt: 1 cycle from IDLE; 0 if already owner.
- Owner throughput: 1 beat/cycle, back-to-back.
- Read latency: accept edge E → crd at E, rdata/rvalid at E+1; rvalid high during the cycle after E+1.
- Write latency: cwr high during the cycle after the accept edge.
- Reads from both requesters interleave correctly; rvalid order equals acceptance order.
- Reset asserted mid-burst: outstanding read discarded, no rvalid after reset release.
- Both req without lock: strict alternation R0,R1,R0,... one beat each.

## Configuration
- CMEM_ARB_FIXED_PRIO_EN defined: every arbitration point (IDLE and beat boundaries) picks R0 when r0_req=1; R1 runs only while R0 idle or when R1 holds lock (bounded by MAX_HOLD); R0 lock has no hold limit; last_owner unused.
- Not defined: round-robin behaviour as above.

## Test plan
- Reset release, R0 write burst addr 0..3, data 0x00010..0x00013, sel=1, no lock → gnt cycle after req, cwr 4 consecutive cycles, caddr_wr 0,1,2,3.
- R1 read addr 0x040, memory returns 0x0ABCD → crd cycle after acceptance, r1_rvalid pulse one cycle later, rdata=0x0ABCD, r0_rvalid stays 0.
- Both req continuously, no lock → grants alternate R0,R1,R0,R1, first grant R0.
- R1 locked 4-beat read (window 0,1,64,65) while R0 requests, MAX_HOLD=8 → all 4 to R1 contiguous, then R0 granted next cycle; with lock held 20 beats → forced switch after 8.
- Reset pulsed one cycle after R1 read acceptance → all outputs 0, no rvalid after release, first grant R0.
- CMEM_ARB_FIXED_PRIO_EN defined, both req, no lock → R0 granted every beat, R1 gnt only after r0_req drops.

Source files
------------

// File: rtl/cmem_arbiter.sv
// cmem_arbiter: two-requester arbiter/sequencer for the shared layer-memory port.
//   Requester 0 = convolution engine, requester 1 = max-pool engine.
//   Grants one beat per cycle with round-robin fairness, supports locked bursts
//   bounded by MAX_HOLD, registers every memory command and returns read data
//   one cycle after the read strobe, tagged to the issuing requester.
// Build option: define CMEM_ARB_FIXED_PRIO_EN for fixed priority (R0 first,
//   R1 lock still bounded by MAX_HOLD, R0 lock unbounded).
// Ports:
//   clk, reset (async, active-low)
//   rN_req/lock/we/sel/addr/wdata : requester N command (N = 0,1)
//   rN_gnt    : requester N owns the port; beat accepted on rN_req & rN_gnt
//   rN_rvalid : one-cycle pulse, rdata belongs to requester N
//   rdata     : registered read data
//   cwr/crd/csel/caddr_wr/caddr_rd/cdata_wr : registered memory command
//   cdata_rd  : memory read data, sampled on the edge ending the crd cycle
module cmem_arbiter #(
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 20,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_lock,
  input  logic          r0_we,
  input  logic [2:0]    r0_sel,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r1_req,
  input  logic          r1_lock,
  input  logic          r1_we,
  input  logic [2:0]    r1_sel,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r0_gnt,
  output logic          r1_gnt,
  output logic          r0_rvalid,
  output logic          r1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          cwr,
  output logic          crd,
  output logic [2:0]    csel,
  output logic [AW-1:0] caddr_wr,
  output logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_wr,
  input  logic [DW-1:0] cdata_rd
);

  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_nxt;
  logic          hold_at_limit;
  logic          acc0;
  logic          acc1;
  logic          acc;
  logic          owner_lock;
  logic          rd_tag;

  logic          beat_we;
  logic [2:0]    beat_sel;
  logic [AW-1:0] beat_addr;
  logic [DW-1:0] beat_wdata;

  // A beat is accepted when the current owner presents a request
  assign acc0          = (state == OWN0) & r0_req;
  assign acc1          = (state == OWN1) & r1_req;
  assign acc           = acc0 | acc1;
  assign hold_at_limit = (hold_cnt == HOLD_LAST);
  assign owner_lock    = (state == OWN1) ? r1_lock : r0_lock;

  // Command payload of the accepted beat
  assign beat_we    = acc1 ? r1_we    : r0_we;
  assign beat_sel   = acc1 ? r1_sel   : r0_sel;
  assign beat_addr  = acc1 ? r1_addr  : r0_addr;
  assign beat_wdata = acc1 ? r1_wdata : r0_wdata;

`ifdef CMEM_ARB_FIXED_PRIO_EN

  // Next-state: R0 wins every arbitration point; only an R1 lock defers it
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (r0_req)      state_nxt = OWN0;
        else if (r1_req) state_nxt = OWN1;
        else             state_nxt = IDLE;
      end
      OWN0: begin
        if (!r0_req) state_nxt = r1_req ? OWN1 : IDLE;
        else         state_nxt = OWN0;
      end
      OWN1: begin
        if (!r1_req)       state_nxt = r0_req ? OWN0 : IDLE;
        else if (!r1_lock) state_nxt = r0_req ? OWN0 : OWN1;
        else               state_nxt = (r0_req && hold_at_limit) ? OWN0 : OWN1;
      end
      default: state_nxt = IDLE;
    endcase
  end

`else

  logic last_owner;

  // Next-state: round-robin on contention, lock bounded by the hold counter
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (r0_req && r1_req) state_nxt = last_owner ? OWN0 : OWN1;
        else if (r0_req)      state_nxt = OWN0;
        else if (r1_req)      state_nxt = OWN1;
        else                  state_nxt = IDLE;
      end
      OWN0: begin
        if (!r0_req)       state_nxt = r1_req ? OWN1 : IDLE;
        else if (!r0_lock) state_nxt = r1_req ? OWN1 : OWN0;
        else               state_nxt = (r1_req && hold_at_limit) ? OWN1 : OWN0;
      end
      OWN1: begin
        if (!r1_req)       state_nxt = r0_req ? OWN0 : IDLE;
        else if (!r1_lock) state_nxt = r0_req ? OWN0 : OWN1;
        else               state_nxt = (r0_req && hold_at_limit) ? OWN0 : OWN1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remember who was served last; updated whenever an owner leaves the port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= 1'b1;
    end else if ((state != IDLE) && (state_nxt != state)) begin
      last_owner <= (state == OWN1);
    end
  end

`endif

  // Hold counter: counts locked beats of the current owner, saturating
  always_comb begin
    hold_cnt_nxt = hold_cnt;
    if (state_nxt != state) begin
      hold_cnt_nxt = '0;
    end else if (acc) begin
      if (!owner_lock)        hold_cnt_nxt = '0;
      else if (!hold_at_limit) hold_cnt_nxt = hold_cnt + HW'(1);
    end
  end

  // State register with grants registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      r0_gnt   <= 1'b0;
      r1_gnt   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      r0_gnt   <= (state_nxt == OWN0);
      r1_gnt   <= (state_nxt == OWN1);
    end
  end

  // Memory command register; address/data/select hold when no beat issues
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cwr      <= 1'b0;
      crd      <= 1'b0;
      csel     <= '0;
      caddr_wr <= '0;
      caddr_rd <= '0;
      cdata_wr <= '0;
      rd_tag   <= 1'b0;
    end else begin
      cwr <= acc & beat_we;
      crd <= acc & ~beat_we;
      if (acc) begin
        csel <= beat_sel;
        if (beat_we) begin
          caddr_wr <= beat_addr;
          cdata_wr <= beat_wdata;
        end else begin
          caddr_rd <= beat_addr;
          rd_tag   <= acc1;
        end
      end
    end
  end

  // Read return: capture memory data one edge after crd and route the pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata     <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      r0_rvalid <= crd & ~rd_tag;
      r1_rvalid <= crd & rd_tag;
      if (crd) rdata <= cdata_rd;
    end
  end

endmodule

// File: tb/tb_cmem_arbiter.sv
// Testbench for cmem_arbiter: directed vector table plus hand-written
// multi-cycle sequences (locked window, forced hold switch, interleaved reads,
// reset during a read, contention behaviour in either arbitration mode).
module tb_cmem_arbiter;

  localparam int unsigned AW       = 12;
  localparam int unsigned DW       = 20;
  localparam int unsigned MAX_HOLD = 8;

`ifdef CMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_req, r0_lock, r0_we;
  logic [2:0]    r0_sel;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r1_req, r1_lock, r1_we;
  logic [2:0]    r1_sel;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] rdata;
  logic          cwr, crd;
  logic [2:0]    csel;
  logic [AW-1:0] caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr;
  logic [DW-1:0] cdata_rd;

  logic          mem_en;
  logic [DW-1:0] cdata_drv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: returns 0x50000 | address while the read strobe is up
  assign cdata_rd = mem_en ? (20'h50000 | {8'h00, caddr_rd}) : cdata_drv;

  cmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_sel(r0_sel),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_sel(r1_sel),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .cwr(cwr), .crd(crd), .csel(csel),
    .caddr_wr(caddr_wr), .caddr_rd(caddr_rd), .cdata_wr(cdata_wr),
    .cdata_rd(cdata_rd)
  );

  typedef struct {
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] cdata;
    logic          gnt0;
    logic          gnt1;
    logic          cwr;
    logic          crd;
    logic          rv0;
    logic          rv1;
    logic [2:0]    csel;
    logic [AW-1:0] caddr_wr;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_wr;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl [10];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, " r0_gnt"}, r0_gnt, 1'b0);
    chk1({tag, " r1_gnt"}, r1_gnt, 1'b0);
    chk1({tag, " r0_rvalid"}, r0_rvalid, 1'b0);
    chk1({tag, " r1_rvalid"}, r1_rvalid, 1'b0);
    chk1({tag, " cwr"}, cwr, 1'b0);
    chk1({tag, " crd"}, crd, 1'b0);
    chkw({tag, " csel"}, 32'(csel), 32'd0);
    chkw({tag, " caddr_wr"}, 32'(caddr_wr), 32'd0);
    chkw({tag, " caddr_rd"}, 32'(caddr_rd), 32'd0);
    chkw({tag, " cdata_wr"}, 32'(cdata_wr), 32'd0);
    chkw({tag, " rdata"}, 32'(rdata), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] win [4];
    logic          exp_g0;
    logic [AW-1:0] exp_a;

    win[0] = 12'd0; win[1] = 12'd1; win[2] = 12'd64; win[3] = 12'd65;

    // R0 write burst 0..3, then R1 read 0x040 returning 0x0ABCD
    tbl[0] = '{1'b1, 1'b1, 12'h000, 20'h00010, 1'b0, 1'b0, 12'h040, 20'h00000,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 12'h000, 20'h00000, 20'h00000};
    tbl[1] = '{1'b1, 1'b1, 12'h000, 20'h00010, 1'b0, 1'b0, 12'h040, 20'h00000,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 12'h000, 12'h000, 20'h00010, 20'h00000};
    tbl[2] = '{1'b1, 1'b1, 12'h001, 20'h00011, 1'b0, 1'b0, 12'h040, 20'h00000,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 12'h001, 12'h000, 20'h00011, 20'h00000};
    tbl[3] = '{1'b1, 1'b1, 12'h002, 20'h00012, 1'b0, 1'b0, 12'h040, 20'h00000,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 12'h002, 12'h000, 20'h00012, 20'h00000};
    tbl[4] = '{1'b1, 1'b1, 12'h003, 20'h00013, 1'b0, 1'b0, 12'h040, 20'h00000,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 12'h003, 12'h000, 20'h00013, 20'h00000};
    tbl[5] = '{1'b0, 1'b1, 12'h003, 20'h00013, 1'b0, 1'b0, 12'h040, 20'h00000,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 12'h003, 12'h000, 20'h00013, 20'h00000};
    tbl[6] = '{1'b0, 1'b1, 12'h003, 20'h00013, 1'b1, 1'b0, 12'h040, 20'h00000,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 12'h003, 12'h000, 20'h00013, 20'h00000};
    tbl[7] = '{1'b0, 1'b1, 12'h003, 20'h00013, 1'b1, 1'b0, 12'h040, 20'h00000,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 12'h003, 12'h040, 20'h00013, 20'h00000};
    tbl[8] = '{1'b0, 1'b1, 12'h003, 20'h00013, 1'b0, 1'b0, 12'h040, 20'h0ABCD,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 12'h003, 12'h040, 20'h00013, 20'h0ABCD};
    tbl[9] = '{1'b0, 1'b1, 12'h003, 20'h00013, 1'b0, 1'b0, 12'h040, 20'h00000,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 12'h003, 12'h040, 20'h00013, 20'h0ABCD};

    reset = 1'b0;
    r0_req = 1'b0; r0_lock = 1'b0; r0_we = 1'b0; r0_sel = 3'd1; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_lock = 1'b0; r1_we = 1'b0; r1_sel = 3'd2; r1_addr = '0; r1_wdata = '0;
    mem_en = 1'b0; cdata_drv = '0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      r0_req = tbl[i].r0_req; r0_we = tbl[i].r0_we; r0_addr = tbl[i].r0_addr;
      r0_wdata = tbl[i].r0_wdata;
      r1_req = tbl[i].r1_req; r1_we = tbl[i].r1_we; r1_addr = tbl[i].r1_addr;
      cdata_drv = tbl[i].cdata;
      tick();
      chk1($sformatf("row%0d r0_gnt", i), r0_gnt, tbl[i].gnt0);
      chk1($sformatf("row%0d r1_gnt", i), r1_gnt, tbl[i].gnt1);
      chk1($sformatf("row%0d cwr", i), cwr, tbl[i].cwr);
      chk1($sformatf("row%0d crd", i), crd, tbl[i].crd);
      chk1($sformatf("row%0d r0_rvalid", i), r0_rvalid, tbl[i].rv0);
      chk1($sformatf("row%0d r1_rvalid", i), r1_rvalid, tbl[i].rv1);
      chkw($sformatf("row%0d csel", i), 32'(csel), 32'(tbl[i].csel));
      chkw($sformatf("row%0d caddr_wr", i), 32'(caddr_wr), 32'(tbl[i].caddr_wr));
      chkw($sformatf("row%0d caddr_rd", i), 32'(caddr_rd), 32'(tbl[i].caddr_rd));
      chkw($sformatf("row%0d cdata_wr", i), 32'(cdata_wr), 32'(tbl[i].cdata_wr));
      chkw($sformatf("row%0d rdata", i), 32'(rdata), 32'(tbl[i].rdata));
    end
    r0_req = 1'b0; r1_req = 1'b0; cdata_drv = '0;
    mem_en = 1'b1;

    // R1 locked 2x2 window read while R0 waits
    r1_req = 1'b1; r1_lock = 1'b1; r1_we = 1'b0; r1_addr = win[0];
    tick();
    chk1("win start r1_gnt", r1_gnt, 1'b1);
    r0_req = 1'b1; r0_we = 1'b1; r0_lock = 1'b0; r0_addr = 12'h300; r0_wdata = 20'h00044;
    for (int k = 0; k < 4; k++) begin
      r1_addr = win[k];
      r1_lock = (k < 3);
      tick();
      chk1($sformatf("win%0d crd", k), crd, 1'b1);
      chkw($sformatf("win%0d caddr_rd", k), 32'(caddr_rd), 32'(win[k]));
      chk1($sformatf("win%0d r1_gnt", k), r1_gnt, (k < 3));
      chk1($sformatf("win%0d r0_gnt", k), r0_gnt, (k == 3));
      chk1($sformatf("win%0d r1_rvalid", k), r1_rvalid, (k > 0));
      chk1($sformatf("win%0d r0_rvalid", k), r0_rvalid, 1'b0);
      if (k > 0) chkw($sformatf("win%0d rdata", k), 32'(rdata), 32'h50000 | 32'(win[k-1]));
    end
    r1_req = 1'b0; r1_lock = 1'b0;
    tick();
    chk1("win r0 cwr", cwr, 1'b1);
    chkw("win r0 caddr_wr", 32'(caddr_wr), 32'h300);
    chkw("win r0 cdata_wr", 32'(cdata_wr), 32'h00044);
    chkw("win r0 csel", 32'(csel), 32'd1);
    chk1("win last r1_rvalid", r1_rvalid, 1'b1);
    chkw("win last rdata", 32'(rdata), 32'h50041);
    r0_req = 1'b0;
    tick();
    chk1("win end r0_gnt", r0_gnt, 1'b0);
    chk1("win end r1_rvalid", r1_rvalid, 1'b0);
    chk1("win end cwr", cwr, 1'b0);

    // R1 lock held with R0 waiting: forced hand-over after MAX_HOLD beats
    r1_req = 1'b1; r1_lock = 1'b1; r1_we = 1'b1; r1_addr = 12'd0; r1_wdata = 20'h60000;
    tick();
    chk1("hold start r1_gnt", r1_gnt, 1'b1);
    r0_req = 1'b1; r0_we = 1'b1; r0_lock = 1'b0; r0_addr = 12'h3AA; r0_wdata = 20'h00055;
    for (int k = 1; k <= 8; k++) begin
      r1_addr = AW'(k);
      r1_wdata = 20'h60000 + DW'(k);
      tick();
      chk1($sformatf("hold%0d cwr", k), cwr, 1'b1);
      chkw($sformatf("hold%0d caddr_wr", k), 32'(caddr_wr), 32'(k));
      chkw($sformatf("hold%0d cdata_wr", k), 32'(cdata_wr), 32'h60000 + 32'(k));
      chk1($sformatf("hold%0d r1_gnt", k), r1_gnt, (k < 8));
      chk1($sformatf("hold%0d r0_gnt", k), r0_gnt, (k == 8));
    end
    r1_req = 1'b0; r1_lock = 1'b0;
    tick();
    chk1("hold r0 cwr", cwr, 1'b1);
    chkw("hold r0 caddr_wr", 32'(caddr_wr), 32'h3AA);
    chk1("hold r0 r0_gnt", r0_gnt, 1'b1);
    r0_req = 1'b0;
    tick();
    chk1("hold end r0_gnt", r0_gnt, 1'b0);
    chk1("hold end cwr", cwr, 1'b0);

    // Interleaved reads: R1 then R0, rvalid follows acceptance order
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 12'h600;
    tick();
    chk1("ilv r1_gnt", r1_gnt, 1'b1);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h500;
    tick();
    chk1("ilv1 crd", crd, 1'b1);
    chkw("ilv1 caddr_rd", 32'(caddr_rd), 32'h600);
    chk1("ilv1 r0_gnt", r0_gnt, 1'b1);
    r1_req = 1'b0;
    tick();
    chk1("ilv2 crd", crd, 1'b1);
    chkw("ilv2 caddr_rd", 32'(caddr_rd), 32'h500);
    chk1("ilv2 r1_rvalid", r1_rvalid, 1'b1);
    chk1("ilv2 r0_rvalid", r0_rvalid, 1'b0);
    chkw("ilv2 rdata", 32'(rdata), 32'h50600);
    r0_req = 1'b0;
    tick();
    chk1("ilv3 crd", crd, 1'b0);
    chk1("ilv3 r0_rvalid", r0_rvalid, 1'b1);
    chk1("ilv3 r1_rvalid", r1_rvalid, 1'b0);
    chkw("ilv3 rdata", 32'(rdata), 32'h50500);
    chk1("ilv3 r0_gnt", r0_gnt, 1'b0);
    tick();
    chk1("ilv4 r0_rvalid", r0_rvalid, 1'b0);

    // Reset asserted while an R1 read is outstanding
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 12'h123;
    tick();
    chk1("rst r1_gnt", r1_gnt, 1'b1);
    tick();
    chk1("rst crd", crd, 1'b1);
    chkw("rst caddr_rd", 32'(caddr_rd), 32'h123);
    r1_req = 1'b0;
    #1 reset = 1'b0;
    #1 check_zero("mid reset");
    tick();
    reset = 1'b1;
    tick();
    chk1("post rst r0_rvalid", r0_rvalid, 1'b0);
    chk1("post rst r1_rvalid", r1_rvalid, 1'b0);
    chk1("post rst crd", crd, 1'b0);
    chk1("post rst r1_gnt", r1_gnt, 1'b0);

    // Contention without lock: alternation (round-robin) or R0 always (fixed)
    r0_req = 1'b1; r0_we = 1'b1; r0_lock = 1'b0; r0_addr = 12'h100; r0_wdata = 20'h00020;
    r1_req = 1'b1; r1_we = 1'b1; r1_lock = 1'b0; r1_addr = 12'h200; r1_wdata = 20'h00030;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_g0 = FIXED ? 1'b1 : (i % 2 == 0);
      chk1($sformatf("both%0d r0_gnt", i), r0_gnt, exp_g0);
      chk1($sformatf("both%0d r1_gnt", i), r1_gnt, ~exp_g0);
      chk1($sformatf("both%0d cwr", i), cwr, (i >= 1));
      if (i >= 1) begin
        exp_a = (FIXED || (i % 2 == 1)) ? 12'h100 : 12'h200;
        chkw($sformatf("both%0d caddr_wr", i), 32'(caddr_wr), 32'(exp_a));
        chkw($sformatf("both%0d cdata_wr", i), 32'(cdata_wr),
             (exp_a == 12'h100) ? 32'h00020 : 32'h00030);
      end
    end
    r0_req = 1'b0;
    tick();
    chk1("r0 drop r1_gnt", r1_gnt, 1'b1);
    chk1("r0 drop cwr", cwr, ~FIXED);
    tick();
    chk1("r1 solo cwr", cwr, 1'b1);
    chkw("r1 solo caddr_wr", 32'(caddr_wr), 32'h200);
    chk1("r1 solo r1_gnt", r1_gnt, 1'b1);
    r1_req = 1'b0;
    tick();
    chk1("final r1_gnt", r1_gnt, 1'b0);
    chk1("final cwr", cwr, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
